// File: rtl/gouram_trace_pkg.sv
// -----------------------------------------------------------------------------
// gouram_trace_pkg
// Shared types and helpers for the gouram trace buffer.
//   state_e    : serialiser FSM state (IDLE, STREAM)
//   num_beats  : number of OUT_WIDTH beats needed to carry one REC_WIDTH record
// -----------------------------------------------------------------------------
package gouram_trace_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  localparam int DROP_CNT_W = 16;

  // ceil(rec_w / out_w); usable in parameter/localparam context.
  function automatic int num_beats(input int rec_w, input int out_w);
    return (rec_w + out_w - 1) / out_w;
  endfunction

endpackage

// File: rtl/gouram_trace_fifo.sv
// -----------------------------------------------------------------------------
// gouram_trace_fifo
// Record store for the trace buffer: W bits x DEPTH entries, show-ahead read.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (pointers/level only)
//   push_i     : write data_i at the tail this edge
//   data_i     : record to write
//   pop_i      : drop the head entry this edge
//   data_o     : head entry (valid whenever empty_o = 0)
//   level_o    : number of entries held
//   full_o     : level_o == DEPTH
//   empty_o    : level_o == 0
// The caller guarantees push_i only when not full (or popping on the same
// edge) and pop_i only when not empty. DEPTH must be a power of two so the
// pointers wrap by natural overflow.
// -----------------------------------------------------------------------------
module gouram_trace_fifo #(
  parameter int W     = 609,
  parameter int DEPTH = 8,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [W-1:0]     data_i,
  input  logic             pop_i,
  output logic [W-1:0]     data_o,
  output logic [LVL_W-1:0] level_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_i, pop_i})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries no reset: contents are only observed behind level_q.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;
  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);

endmodule

// File: rtl/gouram_trace_buffer.sv
// -----------------------------------------------------------------------------
// gouram_trace_buffer
// Buffers wide trace records from the gouram tracer and serialises each one
// into NUM_BEATS = ceil(REC_WIDTH/OUT_WIDTH) beats, LSB first, with the record
// zero-padded at the MSB end.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   trace_valid_i  : record present this cycle (no back-pressure; dropped when full)
//   trace_data_i   : REC_WIDTH-bit record
//   beat_ready_i   : sink accepts the current beat
//   beat_valid_o   : beat available (FSM in STREAM)
//   beat_data_o    : current OUT_WIDTH-bit beat (zero when not valid)
//   beat_last_o    : final beat of the current record
//   level_o        : records held (including the one being streamed)
//   empty_o/full_o : level_o == 0 / level_o == DEPTH
//   overflow_o     : sticky, a record has been dropped since reset
//   drop_cnt_o     : 16-bit saturating drop count, only with the
//                    GOURAM_TRACE_DROP_CNT_EN macro defined
// Handshake: a beat transfers on every rising edge where beat_valid_o and
// beat_ready_i are both 1; while beat_valid_o=1 and beat_ready_i=0 the beat
// data and beat_last_o hold. Once valid, a beat is never withdrawn except by
// reset.
// Debug: the FSM state is the state_q register (type state_e).
// -----------------------------------------------------------------------------
module gouram_trace_buffer
  import gouram_trace_pkg::*;
#(
  parameter int REC_WIDTH = 609,
  parameter int OUT_WIDTH = 64,
  parameter int DEPTH     = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         trace_valid_i,
  input  logic [REC_WIDTH-1:0]         trace_data_i,
  input  logic                         beat_ready_i,
  output logic                         beat_valid_o,
  output logic [OUT_WIDTH-1:0]         beat_data_o,
  output logic                         beat_last_o,
  output logic [$clog2(DEPTH+1)-1:0]   level_o,
  output logic                         empty_o,
  output logic                         full_o,
  output logic                         overflow_o
`ifdef GOURAM_TRACE_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0]        drop_cnt_o
`endif
);

  localparam int NUM_BEATS = num_beats(REC_WIDTH, OUT_WIDTH);
  localparam int PAD_W     = NUM_BEATS * OUT_WIDTH;
  localparam int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int LVL_W     = $clog2(DEPTH + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             overflow_q, overflow_d;

  logic [REC_WIDTH-1:0] head_data;
  logic [LVL_W-1:0]     fifo_level;
  logic                 fifo_full, fifo_empty;
  logic                 streaming, handshake, on_last, push, pop, drop;

  gouram_trace_fifo #(
    .W     (REC_WIDTH),
    .DEPTH (DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (trace_data_i),
    .pop_i   (pop),
    .data_o  (head_data),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Beat selection: the mux is sized to the full counter range so the index
  // width matches exactly; unused slots read as zero.
  logic [PAD_W-1:0]     head_pad;
  logic [OUT_WIDTH-1:0] beat_mux [2**CNT_W];

  assign head_pad = PAD_W'(head_data);

  for (genvar k = 0; k < 2**CNT_W; k++) begin : g_beat
    if (k < NUM_BEATS) begin : g_used
      assign beat_mux[k] = head_pad[k*OUT_WIDTH +: OUT_WIDTH];
    end else begin : g_unused
      assign beat_mux[k] = '0;
    end
  end

  assign streaming = (state_q == STREAM);
  assign handshake = streaming && beat_ready_i;
  assign on_last   = (beat_cnt_q == CNT_W'(NUM_BEATS - 1));
  assign pop       = handshake && on_last;
  // A full buffer still accepts a record when the head leaves on the same edge.
  assign push      = trace_valid_i && (!fifo_full || pop);
  assign drop      = trace_valid_i && fifo_full && !pop;

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d    = STREAM;
          beat_cnt_d = '0;
        end
      end
      STREAM: begin
        if (handshake) begin
          if (on_last) begin
            beat_cnt_d = '0;
            // Keep streaming back-to-back if another record remains after the pop.
            if (!((fifo_level > LVL_W'(1)) || push)) state_d = IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        beat_cnt_d = '0;
      end
    endcase
  end

  assign overflow_d = overflow_q || drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef GOURAM_TRACE_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != {DROP_CNT_W{1'b1}})) drop_cnt_d = drop_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt_o = drop_cnt_q;
`endif

  assign beat_valid_o = streaming;
  assign beat_data_o  = streaming ? beat_mux[beat_cnt_q] : '0;
  assign beat_last_o  = streaming && on_last;
  assign level_o      = fifo_level;
  assign empty_o      = fifo_empty;
  assign full_o       = fifo_full;
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_gouram_trace_buffer.sv
// -----------------------------------------------------------------------------
// tb_gouram_trace_buffer
// Bench for gouram_trace_buffer: default instance checked every cycle against
// a record-queue model, plus directed literal checks, plus two small
// parameter-sweep instances. Drop-count checks follow the
// GOURAM_TRACE_DROP_CNT_EN macro.
// -----------------------------------------------------------------------------
module tb_gouram_trace_buffer;

  localparam int REC_W = 609;
  localparam int OUT_W = 64;
  localparam int DEPTH = 8;
  localparam int NB    = 10;
  localparam int LVL_W = 4;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- main DUT ----------------
  logic              trace_valid_i;
  logic [REC_W-1:0]  trace_data_i;
  logic              beat_ready_i;
  logic              beat_valid_o;
  logic [OUT_W-1:0]  beat_data_o;
  logic              beat_last_o;
  logic [LVL_W-1:0]  level_o;
  logic              empty_o, full_o, overflow_o;
`ifdef GOURAM_TRACE_DROP_CNT_EN
  logic [15:0]       drop_cnt_o;
`endif

  gouram_trace_buffer #(.REC_WIDTH(REC_W), .OUT_WIDTH(OUT_W), .DEPTH(DEPTH)) u_dut (
    .clk           (clk),
    .rst           (rst),
    .trace_valid_i (trace_valid_i),
    .trace_data_i  (trace_data_i),
    .beat_ready_i  (beat_ready_i),
    .beat_valid_o  (beat_valid_o),
    .beat_data_o   (beat_data_o),
    .beat_last_o   (beat_last_o),
    .level_o       (level_o),
    .empty_o       (empty_o),
    .full_o        (full_o),
    .overflow_o    (overflow_o)
`ifdef GOURAM_TRACE_DROP_CNT_EN
    , .drop_cnt_o  (drop_cnt_o)
`endif
  );

  // ---------------- sweep DUT 1: 64/64/8 ----------------
  logic        s1_valid, s1_ready, s1_bvalid, s1_last, s1_empty, s1_full, s1_ovf;
  logic [63:0] s1_data, s1_bdata;
  logic [3:0]  s1_level;
`ifdef GOURAM_TRACE_DROP_CNT_EN
  logic [15:0] s1_drop;
`endif

  gouram_trace_buffer #(.REC_WIDTH(64), .OUT_WIDTH(64), .DEPTH(8)) u_s1 (
    .clk(clk), .rst(rst), .trace_valid_i(s1_valid), .trace_data_i(s1_data),
    .beat_ready_i(s1_ready), .beat_valid_o(s1_bvalid), .beat_data_o(s1_bdata),
    .beat_last_o(s1_last), .level_o(s1_level), .empty_o(s1_empty),
    .full_o(s1_full), .overflow_o(s1_ovf)
`ifdef GOURAM_TRACE_DROP_CNT_EN
    , .drop_cnt_o(s1_drop)
`endif
  );

  // ---------------- sweep DUT 2: 100/32/2 ----------------
  logic        s2_valid, s2_ready, s2_bvalid, s2_last, s2_empty, s2_full, s2_ovf;
  logic [99:0] s2_data;
  logic [31:0] s2_bdata;
  logic [1:0]  s2_level;
`ifdef GOURAM_TRACE_DROP_CNT_EN
  logic [15:0] s2_drop;
`endif

  gouram_trace_buffer #(.REC_WIDTH(100), .OUT_WIDTH(32), .DEPTH(2)) u_s2 (
    .clk(clk), .rst(rst), .trace_valid_i(s2_valid), .trace_data_i(s2_data),
    .beat_ready_i(s2_ready), .beat_valid_o(s2_bvalid), .beat_data_o(s2_bdata),
    .beat_last_o(s2_last), .level_o(s2_level), .empty_o(s2_empty),
    .full_o(s2_full), .overflow_o(s2_ovf)
`ifdef GOURAM_TRACE_DROP_CNT_EN
    , .drop_cnt_o(s2_drop)
`endif
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the queue of records held, in order. The head is being serialised
  // once the stream is active; m_beat is the index of the beat on display.
  logic [REC_W-1:0] exp_q[$];
  int  m_beat   = 0;
  bit  m_active = 1'b0;
  bit  m_ovf    = 1'b0;
  int  m_drops  = 0;
  int  m_pops   = 0;

  always @(posedge clk or posedge rst) begin
    int sz;
    bit hs, pp, ps, dr;
    if (rst) begin
      exp_q.delete();
      m_beat   = 0;
      m_active = 1'b0;
      m_ovf    = 1'b0;
      m_drops  = 0;
    end else begin
      sz = exp_q.size();
      hs = m_active && beat_ready_i;
      pp = hs && (m_beat == NB - 1);
      ps = trace_valid_i && ((sz < DEPTH) || pp);
      dr = trace_valid_i && !ps;
      if (hs) m_beat = pp ? 0 : m_beat + 1;
      if (pp) begin
        void'(exp_q.pop_front());
        m_pops++;
      end
      if (ps) exp_q.push_back(trace_data_i);
      if (dr) begin
        m_ovf = 1'b1;
        if (m_drops < 65535) m_drops++;
      end
      if (m_active) m_active = pp ? (exp_q.size() > 0) : 1'b1;
      else          m_active = (sz > 0);
    end
  end

  // Compare process: every negedge, DUT vs model, plus stall stability.
  logic             prev_stall = 1'b0;
  logic [OUT_W-1:0] prev_data  = '0;
  logic             prev_last  = 1'b0;

  always @(negedge clk) begin
    logic [OUT_W-1:0] e_data;
    logic             e_last;
    int               lvl;
    e_data = '0;
    e_last = 1'b0;
    if (m_active && exp_q.size() > 0) begin
      e_data = OUT_W'(exp_q[0] >> (m_beat * OUT_W));
      e_last = (m_beat == NB - 1);
    end
    lvl = exp_q.size();
    chk("beat_valid", 64'(beat_valid_o), 64'(m_active));
    chk("beat_data",  64'(beat_data_o),  64'(e_data));
    chk("beat_last",  64'(beat_last_o),  64'(e_last));
    chk("level",      64'(level_o),      64'(lvl));
    chk("empty",      64'(empty_o),      64'(lvl == 0));
    chk("full",       64'(full_o),       64'(lvl == DEPTH));
    chk("overflow",   64'(overflow_o),   64'(m_ovf));
`ifdef GOURAM_TRACE_DROP_CNT_EN
    chk("drop_cnt",   64'(drop_cnt_o),   64'(m_drops));
`endif
    if (!rst && prev_stall) begin
      chk("stall_data", 64'(beat_data_o), 64'(prev_data));
      chk("stall_last", 64'(beat_last_o), 64'(prev_last));
    end
    prev_stall = !rst && beat_valid_o && !beat_ready_i;
    prev_data  = beat_data_o;
    prev_last  = beat_last_o;
  end

  // ---------------- driver helpers ----------------
  // All input changes happen 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [REC_W-1:0] rand_rec();
    logic [REC_W-1:0] r;
    r = '0;
    for (int i = 0; i < 20; i++) r = {r[REC_W-33:0], 32'($urandom())};
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic summary();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
  endtask

  initial begin
    #500000;
    checks++;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    summary();
    $finish;
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [REC_W-1:0] rec;
    logic [63:0]      lit;
    int               sent, pops0, seen;
    bit               got;

    rst = 1'b1;
    trace_valid_i = 1'b0; trace_data_i = '0; beat_ready_i = 1'b0;
    s1_valid = 1'b0; s1_data = '0; s1_ready = 1'b0;
    s2_valid = 1'b0; s2_data = '0; s2_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_valid", 64'(beat_valid_o), 64'd0);
    chk("rst_level", 64'(level_o),      64'd0);
    chk("rst_empty", 64'(empty_o),      64'd1);
    chk("rst_full",  64'(full_o),       64'd0);
    chk("rst_ovf",   64'(overflow_o),   64'd0);
    chk("rst_data",  64'(beat_data_o),  64'd0);

    // Single default record, ready high: 10 consecutive beats
    rec = '0;
    rec[63:0]    = 64'h1;
    rec[127:64]  = 64'h2;
    rec[608:576] = 33'h1_2345_6789;
    step();
    beat_ready_i = 1'b1;
    trace_valid_i = 1'b1; trace_data_i = rec;
    step();
    trace_valid_i = 1'b0;
    @(negedge clk);
    chk("lat_valid_e0", 64'(beat_valid_o), 64'd0);
    chk("lat_level_e0", 64'(level_o),      64'd1);
    for (int k = 0; k < NB; k++) begin
      @(negedge clk);
      lit = (k == 0) ? 64'h1 : (k == 1) ? 64'h2 : (k == 9) ? 64'h0000_0001_2345_6789 : 64'h0;
      chk("rec0_valid", 64'(beat_valid_o), 64'd1);
      chk("rec0_data",  beat_data_o,       lit);
      chk("rec0_last",  64'(beat_last_o),  64'(k == 9));
    end
    @(negedge clk);
    chk("rec0_done", 64'(beat_valid_o), 64'd0);

    // 9 pushes with the sink stalled: one drop
    step();
    beat_ready_i = 1'b0;
    for (int i = 0; i < 9; i++) begin
      trace_valid_i = 1'b1; trace_data_i = rand_rec();
      step();
    end
    trace_valid_i = 1'b0;
    @(negedge clk);
    chk("ovf_full",  64'(full_o),     64'd1);
    chk("ovf_level", 64'(level_o),    64'd8);
    chk("ovf_flag",  64'(overflow_o), 64'd1);
`ifdef GOURAM_TRACE_DROP_CNT_EN
    chk("ovf_drops", 64'(drop_cnt_o), 64'd1);
`endif

    // Full buffer: push on the same edge as the last-beat handshake
    step();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      trace_valid_i = 1'b1; trace_data_i = rand_rec();
      step();
    end
    trace_valid_i = 1'b0;
    @(negedge clk);
    chk("fill_full", 64'(full_o),     64'd1);
    chk("fill_ovf",  64'(overflow_o), 64'd0);
    step();
    beat_ready_i = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (beat_last_o) begin
        got = 1'b1;
        break;
      end
      step();
    end
    chk("wait_last", 64'(got), 64'd1);
    trace_valid_i = 1'b1; trace_data_i = rand_rec();
    step();
    trace_valid_i = 1'b0;
    beat_ready_i = 1'b0;
    @(negedge clk);
    chk("pp_level", 64'(level_o),    64'd8);
    chk("pp_full",  64'(full_o),     64'd1);
    chk("pp_ovf",   64'(overflow_o), 64'd0);
    step();
    beat_ready_i = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (empty_o && !beat_valid_o) begin
        got = 1'b1;
        break;
      end
    end
    chk("drain1", 64'(got), 64'd1);

    // 50 records with random sink stalls
    pops0 = m_pops;
    sent = 0;
    for (int c = 0; c < 3000 && sent < 50; c++) begin
      beat_ready_i = 1'($urandom_range(0, 1));
      if (exp_q.size() < DEPTH - 1 && $urandom_range(0, 3) != 0) begin
        trace_valid_i = 1'b1; trace_data_i = rand_rec();
        sent++;
      end else begin
        trace_valid_i = 1'b0;
      end
      step();
    end
    trace_valid_i = 1'b0;
    for (int c = 0; c < 3000 && (m_pops - pops0) < 50; c++) begin
      beat_ready_i = 1'($urandom_range(0, 1));
      step();
    end
    chk("rand_sent", 64'(sent),           64'd50);
    chk("rand_pops", 64'(m_pops - pops0), 64'd50);
    chk("rand_ovf",  64'(overflow_o),     64'd0);

    // Reset during beat 4 of a record with 3 held
    beat_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      trace_valid_i = 1'b1; trace_data_i = rand_rec();
      step();
    end
    trace_valid_i = 1'b0;
    beat_ready_i = 1'b1;
    repeat (4) step();
    beat_ready_i = 1'b0;
    chk("pre_rst_valid", 64'(beat_valid_o), 64'd1);
    chk("pre_rst_level", 64'(level_o),      64'd3);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(beat_valid_o), 64'd0);
    chk("mid_rst_level", 64'(level_o),      64'd0);
    chk("mid_rst_empty", 64'(empty_o),      64'd1);
    step();
    rst = 1'b0;
    beat_ready_i = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (beat_valid_o) seen++;
    end
    chk("no_resume", 64'(seen), 64'd0);

    // Sweep: 64/64 -> one beat per record, beat_last always set
    s1_ready = 1'b1;
    s1_valid = 1'b1; s1_data = 64'hDEAD_BEEF_0123_4567;
    step();
    s1_data = 64'h0F0F_1234_A5A5_8001;
    step();
    s1_valid = 1'b0;
    @(negedge clk);
    chk("s1_a_data", s1_bdata,          64'hDEAD_BEEF_0123_4567);
    chk("s1_a_last", 64'(s1_last),      64'd1);
    @(negedge clk);
    chk("s1_b_data", s1_bdata,          64'h0F0F_1234_A5A5_8001);
    chk("s1_b_last", 64'(s1_last),      64'd1);
    @(negedge clk);
    chk("s1_idle",   64'(s1_bvalid),    64'd0);
    chk("s1_ovf",    64'(s1_ovf),       64'd0);
`ifdef GOURAM_TRACE_DROP_CNT_EN
    chk("s1_drops",  64'(s1_drop),      64'd0);
`endif

    // Sweep: 100/32/2 -> four beats, top 28 bits zero, third push dropped
    step();
    s2_ready = 1'b0;
    s2_valid = 1'b1; s2_data = 100'hA_1234_5678_9ABC_DEF0_1357_9BDF;
    step();
    s2_data = 100'h5_0000_0001_0000_0002_0000_0003;
    step();
    s2_data = 100'hF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
    step();
    s2_valid = 1'b0;
    @(negedge clk);
    chk("s2_full",  64'(s2_full),  64'd1);
    chk("s2_level", 64'(s2_level), 64'd2);
    chk("s2_ovf",   64'(s2_ovf),   64'd1);
`ifdef GOURAM_TRACE_DROP_CNT_EN
    chk("s2_drops", 64'(s2_drop),  64'd1);
`endif
    step();
    s2_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      case (k)
        0: lit = 64'h1357_9BDF;
        1: lit = 64'h9ABC_DEF0;
        2: lit = 64'h1234_5678;
        3: lit = 64'h0000_000A;
        4: lit = 64'h0000_0003;
        5: lit = 64'h0000_0002;
        6: lit = 64'h0000_0001;
        default: lit = 64'h0000_0005;
      endcase
      chk("s2_valid", 64'(s2_bvalid), 64'd1);
      chk("s2_data",  64'(s2_bdata),  lit);
      chk("s2_last",  64'(s2_last),   64'((k % 4) == 3));
    end
    @(negedge clk);
    chk("s2_idle",  64'(s2_bvalid), 64'd0);
    chk("s2_empty", 64'(s2_empty),  64'd1);

    summary();
    $finish;
  end

endmodule
